// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and register-file types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int N_WORDS       = 32;
  localparam int ADDRESS_WIDTH = $clog2(N_WORDS);
  localparam int N_READ_PORTS  = 2;

  typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]    reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, r0 never busy.
// Latency: set/clear visible one edge later; async clear on reset.
// Backpressure: none here; the top turns busy into a stall.
module rf_scoreboard #(
  parameter int N_WORDS       = mips_pkg::N_WORDS,
  parameter int ADDRESS_WIDTH = $clog2(N_WORDS)
) (
  input  logic                     clk,
  input  logic                     asyn_n_rst,
  input  logic                     issue,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] rd0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] rd1,
  output logic [N_WORDS-1:0]       busy
);

  logic [N_WORDS-1:0] busy_q;
  logic [N_WORDS-1:0] busy_d;

  // Next busy vector: issue beats a same-cycle writeback; r0 is pinned to 0.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < N_WORDS; r++) begin
      if (issue && (issue_rd == ADDRESS_WIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((we0 && (rd0 == ADDRESS_WIDTH'(r))) ||
                   (we1 && (rd1 == ADDRESS_WIDTH'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/mips_rf_mp.sv
// Multi-port MIPS register file: N_READ comb reads, 2 writes, busy scoreboard.
// Latency: reads 0 cycles; writes/busy 1 edge (same cycle via bypass if enabled).
// Backpressure: none accepted; stall flags a read of a busy register.
module mips_rf_mp #(
  parameter int DATA_WIDTH    = mips_pkg::DATA_WIDTH,
  parameter int N_WORDS       = mips_pkg::N_WORDS,
  parameter int N_READ        = mips_pkg::N_READ_PORTS,
  parameter int BYPASS        = 1,
  parameter int ADDRESS_WIDTH = $clog2(N_WORDS)
) (
  input  logic                                  clk,
  input  logic                                  asyn_n_rst,
  input  logic [N_READ-1:0][ADDRESS_WIDTH-1:0]  rs,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]     Qs,
  output logic [N_READ-1:0]                     rs_busy,
  output logic                                  stall,
  input  logic [N_READ-1:0]                     rs_en,
  input  logic                                  we0,
  input  logic [ADDRESS_WIDTH-1:0]              rd0,
  input  logic [DATA_WIDTH-1:0]                 data0,
  input  logic                                  we1,
  input  logic [ADDRESS_WIDTH-1:0]              rd1,
  input  logic [DATA_WIDTH-1:0]                 data1,
  input  logic                                  issue,
  input  logic [ADDRESS_WIDTH-1:0]              issue_rd
);

  localparam bit BYP = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] mem [N_WORDS];
  logic [N_WORDS-1:0]    busy;
  logic                  wr0_ok;
  logic                  wr1_ok;

  // Writes to r0 are dropped; reset also masks writes so bypass cannot leak them.
  assign wr0_ok = asyn_n_rst && we0 && (rd0 != '0);
  assign wr1_ok = asyn_n_rst && we1 && (rd1 != '0);

  // Storage array; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      for (int w = 0; w < N_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        mem[rd0] <= data0;
      end
      if (wr1_ok) begin
        mem[rd1] <= data1;
      end
    end
  end

  rf_scoreboard #(
    .N_WORDS       (N_WORDS),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .asyn_n_rst (asyn_n_rst),
    .issue      (issue),
    .issue_rd   (issue_rd),
    .we0        (wr0_ok),
    .rd0        (rd0),
    .we1        (wr1_ok),
    .rd1        (rd1),
    .busy       (busy)
  );

  for (genvar i = 0; i < N_READ; i++) begin : g_read
    logic [DATA_WIDTH-1:0] q;
    logic                  b;
    logic                  hit0;
    logic                  hit1;

    assign hit0 = BYP && wr0_ok && (rd0 == rs[i]);
    assign hit1 = BYP && wr1_ok && (rd1 == rs[i]);

    // Read mux: r0 reads zero, then port-1 bypass, port-0 bypass, array.
    always_comb begin
      q = '0;
      b = 1'b0;
      if (rs[i] != '0) begin
        if (hit1) begin
          q = data1;
        end else if (hit0) begin
          q = data0;
        end else begin
          q = mem[rs[i]];
        end
        b = busy[rs[i]] && !(hit0 || hit1);
      end
    end

    assign Qs[i]      = q;
    assign rs_busy[i] = b;
  end

  assign stall = |(rs_busy & rs_en);

endmodule

// File: tb/tb_mips_rf_mp.sv
// Directed bench for mips_rf_mp, driving a BYPASS=1 and a BYPASS=0 copy in parallel.
// Latency: checks comb outputs mid-cycle, one edge after writes/issues.
// Backpressure: n/a.
module tb_mips_rf_mp;

  logic             clk = 1'b0;
  logic             asyn_n_rst;
  logic [1:0][4:0]  rs;
  logic [1:0]       rs_en;
  logic             we0, we1, issue;
  logic [4:0]       rd0, rd1, issue_rd;
  logic [31:0]      data0, data1;
  logic [1:0][31:0] q_b, q_n;
  logic [1:0]       busy_b, busy_n;
  logic             stall_b, stall_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_rf_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .asyn_n_rst(asyn_n_rst), .rs(rs), .Qs(q_b), .rs_busy(busy_b),
    .stall(stall_b), .rs_en(rs_en), .we0(we0), .rd0(rd0), .data0(data0),
    .we1(we1), .rd1(rd1), .data1(data1), .issue(issue), .issue_rd(issue_rd)
  );

  mips_rf_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .asyn_n_rst(asyn_n_rst), .rs(rs), .Qs(q_n), .rs_busy(busy_n),
    .stall(stall_n), .rs_en(rs_en), .we0(we0), .rd0(rd0), .data0(data0),
    .we1(we1), .rd1(rd1), .data1(data1), .issue(issue), .issue_rd(issue_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue = 1'b0;
    rd0 = '0; rd1 = '0; issue_rd = '0;
    data0 = '0; data1 = '0;
  endtask

  initial begin
    asyn_n_rst = 1'b0;
    rs = '0;
    rs_en = '0;
    idle();

    // During reset, with a write presented: nothing visible.
    we0 = 1'b1; rd0 = 5'd5; data0 = 32'h1234_5678; rs[0] = 5'd5;
    #2;
    chk("rst_q0_b", q_b[0], 32'h0);
    chk("rst_busy_b", {30'b0, busy_b}, 32'h0);
    chk("rst_stall_b", {31'b0, stall_b}, 32'h0);
    #10;
    idle();
    asyn_n_rst = 1'b1;
    #1;

    // Every address on both ports reads zero and not busy after reset.
    for (int r = 0; r < 32; r++) begin
      rs[0] = 5'(r);
      rs[1] = 5'(31 - r);
      rs_en = 2'b11;
      #1;
      chk("rst_all_q_b", {q_b[1] | q_b[0]}, 32'h0);
      chk("rst_all_q_n", {q_n[1] | q_n[0]}, 32'h0);
      chk("rst_all_busy", {28'b0, busy_b, busy_n}, 32'h0);
    end
    rs_en = '0;

    // Port-0 write to r5 appears after the edge.
    tick();
    we0 = 1'b1; rd0 = 5'd5; data0 = 32'hDEAD_BEEF;
    tick();
    idle();
    rs[0] = 5'd5;
    #1;
    chk("r5_q0_b", q_b[0], 32'hDEAD_BEEF);
    chk("r5_q0_n", q_n[0], 32'hDEAD_BEEF);

    // r0 write and r0 issue are both ignored.
    we0 = 1'b1; rd0 = 5'd0; data0 = 32'hFFFF_FFFF;
    we1 = 1'b1; rd1 = 5'd0; data1 = 32'hFFFF_FFFF;
    issue = 1'b1; issue_rd = 5'd0;
    rs = '0; rs_en = 2'b11;
    #1;
    chk("r0_byp_q0", q_b[0], 32'h0);
    tick();
    idle();
    #1;
    chk("r0_q_b", {q_b[1] | q_b[0]}, 32'h0);
    chk("r0_q_n", {q_n[1] | q_n[0]}, 32'h0);
    chk("r0_busy", {28'b0, busy_b, busy_n}, 32'h0);
    chk("r0_stall", {30'b0, stall_b, stall_n}, 32'h0);
    rs_en = '0;

    // Dual write to r7: port 1 wins; bypass shows it, read-old shows 0.
    we0 = 1'b1; rd0 = 5'd7; data0 = 32'h1;
    we1 = 1'b1; rd1 = 5'd7; data1 = 32'h2;
    rs[0] = 5'd7;
    #1;
    chk("r7_same_b", q_b[0], 32'h2);
    chk("r7_same_n", q_n[0], 32'h0);
    tick();
    idle();
    #1;
    chk("r7_after_b", q_b[0], 32'h2);
    chk("r7_after_n", q_n[0], 32'h2);

    // Issue r9: no self-stall, then stall until writeback.
    rs[1] = 5'd9; rs_en = 2'b10;
    issue = 1'b1; issue_rd = 5'd9;
    #1;
    chk("r9_issue_nostall", {31'b0, stall_b}, 32'h0);
    tick();
    idle();
    #1;
    chk("r9_stall_b", {31'b0, stall_b}, 32'h1);
    chk("r9_stall_n", {31'b0, stall_n}, 32'h1);
    chk("r9_rsbusy1", {31'b0, busy_b[1]}, 32'h1);
    rs_en = 2'b01;
    #1;
    chk("r9_en_off", {31'b0, stall_b}, 32'h0);
    rs_en = 2'b10;
    tick();
    chk("r9_stall_hold", {31'b0, stall_b}, 32'h1);
    we1 = 1'b1; rd1 = 5'd9; data1 = 32'hA5;
    #1;
    chk("r9_wb_stall_b", {31'b0, stall_b}, 32'h0);
    chk("r9_wb_q1_b", q_b[1], 32'hA5);
    chk("r9_wb_stall_n", {31'b0, stall_n}, 32'h1);
    chk("r9_wb_q1_n", q_n[1], 32'h0);
    tick();
    idle();
    #1;
    chk("r9_done_busy", {28'b0, busy_b, busy_n}, 32'h0);
    chk("r9_done_q1_n", q_n[1], 32'hA5);

    // Issue and writeback on r3 together: data lands, busy stays set.
    issue = 1'b1; issue_rd = 5'd3;
    we0 = 1'b1; rd0 = 5'd3; data0 = 32'h10;
    tick();
    idle();
    rs[0] = 5'd3; rs_en = 2'b01;
    #1;
    chk("r3_q0", q_b[0], 32'h10);
    chk("r3_busy_b", {31'b0, busy_b[0]}, 32'h1);
    chk("r3_busy_n", {31'b0, busy_n[0]}, 32'h1);
    chk("r3_stall", {31'b0, stall_b}, 32'h1);

    // Asynchronous reset between edges with r4 busy and holding 32'h55.
    we0 = 1'b1; rd0 = 5'd4; data0 = 32'h55;
    tick();
    idle();
    issue = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    rs[0] = 5'd4;
    #1;
    chk("r4_pre_q0", q_b[0], 32'h55);
    chk("r4_pre_stall", {31'b0, stall_b}, 32'h1);
    asyn_n_rst = 1'b0;
    #1;
    chk("r4_rst_q0_b", q_b[0], 32'h0);
    chk("r4_rst_q0_n", q_n[0], 32'h0);
    chk("r4_rst_busy", {28'b0, busy_b, busy_n}, 32'h0);
    chk("r4_rst_stall", {30'b0, stall_b, stall_n}, 32'h0);

    // Write and issue held through reset across an edge are lost.
    we0 = 1'b1; rd0 = 5'd6; data0 = 32'h77;
    issue = 1'b1; issue_rd = 5'd6;
    tick();
    idle();
    asyn_n_rst = 1'b1;
    rs[0] = 5'd6; rs[1] = 5'd3; rs_en = 2'b11;
    #1;
    chk("r6_lost_q", q_n[0], 32'h0);
    chk("r6_lost_busy", {30'b0, busy_b}, 32'h0);
    chk("r3_cleared_q", q_b[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
